collision_scheduler: RTL and testbench
======================================

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 SHALL have parameter N_GHOSTS, default 4, number of ghosts checked per frame (1..8).
REQ-002 SHALL have parameter TILE_SHIFT, default 4, log2 of tile size in pixels for the display-to-map-index conversion.
REQ-003 SHALL have parameter START_LIVES, default 3, lives loaded at reset (1..7).
REQ-004 SHALL have parameter DEATH_HOLD, default 2, frame ticks skipped after a death (0..15).
REQ-005 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: frame_tick  in  1  one-cycle pulse starting a check round.
REQ-007 SHALL have ports: pacman_pos_x  in  11  pixel x; pacman_pos_y  in  10  pixel y.
REQ-008 SHALL have ports: ghost_pos_x  in  11*N_GHOSTS  packed, ghost i at [11i+10:11i]; ghost_pos_y  in  10*N_GHOSTS  packed, ghost i at [10i+9:10i].
REQ-009 SHALL have ports: busy  out  1  round in progress; done  out  1  one-cycle round-complete pulse.
REQ-010 SHALL have ports: pacman_is_dead  out  1  one-cycle death pulse; hit_ghost_id  out  3  lowest colliding ghost; hit_mask  out  N_GHOSTS  all colliding ghosts.
REQ-011 SHALL have ports: lives  out  3  remaining lives; game_over  out  1  sticky; overrun  out  1  sticky, frame_tick arrived while busy.

Function
REQ-012 SHALL implement states IDLE, CHECK, REPORT, HOLD.
REQ-013 SHALL, in IDLE with frame_tick=1 and game_over=0, snapshot all position inputs into registers, clear the hit accumulator, set ghost index 0, go to CHECK.
REQ-014 SHALL, in CHECK, compare one ghost per cycle: collision when (pos_x>>TILE_SHIFT) and (pos_y>>TILE_SHIFT) both equal Pac-Man's, using snapshot values only.
REQ-015 SHALL leave CHECK for REPORT after ghost N_GHOSTS-1 is compared (CHECK lasts exactly N_GHOSTS cycles).
REQ-016 SHALL, in REPORT, assert done for one cycle; done SHALL first be high N_GHOSTS+1 cycles after the frame_tick cycle.
REQ-017 SHALL, when hit_mask non-zero in REPORT, pulse pacman_is_dead with done, set hit_ghost_id to lowest set bit, decrement lives by exactly one regardless of hit count.
REQ-018 SHALL hold hit_mask and hit_ghost_id stable from done until the next round's done.
REQ-019 SHALL set game_over when lives reaches 0; afterwards frame_tick SHALL be ignored until reset.
REQ-020 SHALL, after a death with lives>0 and DEATH_HOLD>0, enter HOLD and ignore the next DEATH_HOLD frame ticks (no round, no done), then return to IDLE; DEATH_HOLD=0 returns directly to IDLE.
REQ-021 SHALL assert busy in CHECK and REPORT; frame_tick there SHALL be dropped and set overrun.
REQ-022 SHALL treat frame_tick in HOLD as consumed by the hold counter, not as overrun.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-round, go to IDLE immediately: busy=0, done=0, pacman_is_dead=0, hit_ghost_id=0, hit_mask=0, lives=START_LIVES, game_over=0, overrun=0, hold counter=0.
REQ-024 SHALL discard any partial round on reset; no done follows reset release until a new frame_tick.

Configuration
REQ-025 SHALL, with COLLISION_FRIGHTENED_EN defined, add input ghost_frightened (N_GHOSTS, snapshotted with positions) and output ghost_eaten (N_GHOSTS, one-cycle pulse with done).
REQ-026 SHALL, with COLLISION_FRIGHTENED_EN defined, exclude frightened colliding ghosts from hit_mask and report them in ghost_eaten; if any non-frightened hit exists that frame, death wins and ghost_eaten SHALL be 0.
REQ-027 SHALL, without COLLISION_FRIGHTENED_EN, omit both ports and treat every collision as fatal.

Verification
REQ-028 Pac-Man (100,100), all ghosts (300,300), frame_tick -> done at cycle +5, pacman_is_dead=0, hit_mask=0, lives=3.
REQ-029 Pac-Man (33,40), ghost2 (47,35) (same tile 2,2), ghost3 (32,47) -> done with pacman_is_dead=1, hit_mask=4'b1100, hit_ghost_id=2, lives=2.
REQ-030 Death with DEATH_HOLD=2, then three frame ticks -> first two produce no done, third produces done; overrun stays 0.
REQ-031 Three consecutive fatal rounds (hold 0) -> lives 2,1,0, game_over=1 at third done; further frame_tick -> busy stays 0.
REQ-032 frame_tick at cycle +2 of a round -> overrun=1, round result unchanged; rst_n low at cycle +3 -> all outputs reset values, no done.
REQ-033 COLLISION_FRIGHTENED_EN, ghost1 frightened collides alone -> ghost_eaten=4'b0010, pacman_is_dead=0; plus ghost0 non-frightened collides -> pacman_is_dead=1, ghost_eaten=0.

Source files
------------

// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - per-frame Pac-Man/ghost tile collision scheduler, lives and death hold.
// Optional macro COLLISION_FRIGHTENED_EN adds ghost_frightened / ghost_eaten.
module collision_scheduler #(
  parameter int N_GHOSTS    = 4,
  parameter int TILE_SHIFT  = 4,
  parameter int START_LIVES = 3,
  parameter int DEATH_HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_tick,
  input  logic [10:0]              pacman_pos_x,
  input  logic [9:0]               pacman_pos_y,
  input  logic [11*N_GHOSTS-1:0]   ghost_pos_x,
  input  logic [10*N_GHOSTS-1:0]   ghost_pos_y,
`ifdef COLLISION_FRIGHTENED_EN
  input  logic [N_GHOSTS-1:0]      ghost_frightened,
  output logic [N_GHOSTS-1:0]      ghost_eaten,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     pacman_is_dead,
  output logic [2:0]               hit_ghost_id,
  output logic [N_GHOSTS-1:0]      hit_mask,
  output logic [2:0]               lives,
  output logic                     game_over,
  output logic                     overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;
  localparam logic [2:0] LAST_IDX  = 3'(N_GHOSTS - 1);
  localparam logic [3:0] HOLD_LOAD = 4'(DEATH_HOLD);

  logic [1:0]              state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [10:0]             px_q, px_d;
  logic [9:0]              py_q, py_d;
  logic [11*N_GHOSTS-1:0]  gx_q, gx_d;
  logic [10*N_GHOSTS-1:0]  gy_q, gy_d;
  logic [N_GHOSTS-1:0]     acc_q, acc_d;
  logic [N_GHOSTS-1:0]     hit_mask_q, hit_mask_d;
  logic [2:0]              hit_id_q, hit_id_d;
  logic [2:0]              lives_q, lives_d;
  logic [3:0]              hold_q, hold_d;
  logic                    done_q, done_d;
  logic                    dead_q, dead_d;
  logic                    game_over_q, game_over_d;
  logic                    overrun_q, overrun_d;

  logic                    start;
  logic                    last;
  logic                    match;
  logic                    fatal;
  logic [N_GHOSTS-1:0]     onehot;
  logic [10:0]             gx_sel;
  logic [9:0]              gy_sel;
  logic [2:0]              low_id;

  assign start = (state_q == S_IDLE) && frame_tick && !game_over_q;
  assign last  = (state_q == S_CHECK) && (idx_q == LAST_IDX);

  // Only the snapshot is compared, so inputs may move freely during a round.
  always_comb begin
    gx_sel = '0;
    gy_sel = '0;
    onehot = '0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      if (idx_q == 3'(i)) begin
        gx_sel    = gx_q[i*11 +: 11];
        gy_sel    = gy_q[i*10 +: 10];
        onehot[i] = 1'b1;
      end
    end
    match = ((gx_sel >> TILE_SHIFT) == (px_q >> TILE_SHIFT)) &&
            ((gy_sel >> TILE_SHIFT) == (py_q >> TILE_SHIFT));
  end

`ifdef COLLISION_FRIGHTENED_EN
  logic [N_GHOSTS-1:0] fr_q, fr_d, eat_acc_q, eat_acc_d, eaten_q, eaten_d;
  logic                fr_sel;

  assign fr_sel = |(fr_q & onehot);
  assign fatal  = match && !fr_sel;

  always_comb begin
    fr_d      = fr_q;
    eat_acc_d = eat_acc_q;
    eaten_d   = '0;
    if (start) begin
      fr_d      = ghost_frightened;
      eat_acc_d = '0;
    end else if (state_q == S_CHECK) begin
      eat_acc_d = eat_acc_q | (onehot & fr_q & {N_GHOSTS{match}});
      // A fatal hit in the same frame cancels any eating.
      if (last) eaten_d = (|acc_d) ? '0 : eat_acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr_q      <= '0;
      eat_acc_q <= '0;
      eaten_q   <= '0;
    end else begin
      fr_q      <= fr_d;
      eat_acc_q <= eat_acc_d;
      eaten_q   <= eaten_d;
    end
  end

  assign ghost_eaten = eaten_q;
`else
  assign fatal = match;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    px_d        = px_q;
    py_d        = py_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    acc_d       = acc_q;
    hit_mask_d  = hit_mask_q;
    hit_id_d    = hit_id_q;
    lives_d     = lives_q;
    hold_d      = hold_q;
    game_over_d = game_over_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;
    dead_d      = 1'b0;
    low_id      = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          px_d    = pacman_pos_x;
          py_d    = pacman_pos_y;
          gx_d    = ghost_pos_x;
          gy_d    = ghost_pos_y;
          acc_d   = '0;
          idx_d   = 3'd0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (frame_tick) overrun_d = 1'b1;
        acc_d = acc_q | (onehot & {N_GHOSTS{fatal}});
        idx_d = idx_q + 3'd1;
        if (last) begin
          for (int i = N_GHOSTS - 1; i >= 0; i--) begin
            if (acc_d[i]) low_id = 3'(i);
          end
          state_d    = S_REPORT;
          done_d     = 1'b1;
          hit_mask_d = acc_d;
          hit_id_d   = low_id;
          if (|acc_d) begin
            dead_d  = 1'b1;
            lives_d = lives_q - 3'd1;
            if (lives_q == 3'd1) game_over_d = 1'b1;
          end
        end
      end
      S_REPORT: begin
        if (frame_tick) overrun_d = 1'b1;
        if (dead_q && !game_over_q && (DEATH_HOLD > 0)) begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (frame_tick) begin
          hold_d = hold_q - 4'd1;
          if (hold_q == 4'd1) state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      px_q        <= '0;
      py_q        <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
      acc_q       <= '0;
      hit_mask_q  <= '0;
      hit_id_q    <= 3'd0;
      lives_q     <= 3'(START_LIVES);
      hold_q      <= 4'd0;
      done_q      <= 1'b0;
      dead_q      <= 1'b0;
      game_over_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      px_q        <= px_d;
      py_q        <= py_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      acc_q       <= acc_d;
      hit_mask_q  <= hit_mask_d;
      hit_id_q    <= hit_id_d;
      lives_q     <= lives_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      dead_q      <= dead_d;
      game_over_q <= game_over_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy           = (state_q == S_CHECK) || (state_q == S_REPORT);
  assign done           = done_q;
  assign pacman_is_dead = dead_q;
  assign hit_ghost_id   = hit_id_q;
  assign hit_mask       = hit_mask_q;
  assign lives          = lives_q;
  assign game_over      = game_over_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// tb/tb_collision_scheduler.sv - scoreboard bench for collision_scheduler (main DUT hold 2, second DUT hold 0).
module tb_collision_scheduler;

  localparam int NG = 4;
  localparam int TS = 4;
  localparam int DH = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           frame_tick;
  logic [10:0]    pacman_pos_x;
  logic [9:0]     pacman_pos_y;
  logic [11*NG-1:0] ghost_pos_x;
  logic [10*NG-1:0] ghost_pos_y;
  logic           busy, done, pacman_is_dead, game_over, overrun;
  logic [2:0]     hit_ghost_id, lives;
  logic [NG-1:0]  hit_mask;
  logic           h0_busy, h0_done, h0_dead, h0_go, h0_ovr;
  logic [2:0]     h0_id, h0_lives;
  logic [NG-1:0]  h0_mask;
`ifdef COLLISION_FRIGHTENED_EN
  logic [NG-1:0]  ghost_frightened;
  logic [NG-1:0]  ghost_eaten, h0_eaten;
`endif

  always #5 clk = ~clk;

  collision_scheduler #(.N_GHOSTS(NG), .TILE_SHIFT(TS), .START_LIVES(3), .DEATH_HOLD(DH)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .pacman_pos_x(pacman_pos_x), .pacman_pos_y(pacman_pos_y),
    .ghost_pos_x(ghost_pos_x), .ghost_pos_y(ghost_pos_y),
`ifdef COLLISION_FRIGHTENED_EN
    .ghost_frightened(ghost_frightened), .ghost_eaten(ghost_eaten),
`endif
    .busy(busy), .done(done), .pacman_is_dead(pacman_is_dead),
    .hit_ghost_id(hit_ghost_id), .hit_mask(hit_mask), .lives(lives),
    .game_over(game_over), .overrun(overrun)
  );

  collision_scheduler #(.N_GHOSTS(NG), .TILE_SHIFT(TS), .START_LIVES(3), .DEATH_HOLD(0)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .pacman_pos_x(pacman_pos_x), .pacman_pos_y(pacman_pos_y),
    .ghost_pos_x(ghost_pos_x), .ghost_pos_y(ghost_pos_y),
`ifdef COLLISION_FRIGHTENED_EN
    .ghost_frightened(ghost_frightened), .ghost_eaten(h0_eaten),
`endif
    .busy(h0_busy), .done(h0_done), .pacman_is_dead(h0_dead),
    .hit_ghost_id(h0_id), .hit_mask(h0_mask), .lives(h0_lives),
    .game_over(h0_go), .overrun(h0_ovr)
  );

  typedef struct {
    logic          dead;
    logic [NG-1:0] mask;
    logic [2:0]    id;
    logic [2:0]    lives;
    logic          go;
    logic [NG-1:0] eaten;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   assertions = 0;
  int   failures   = 0;
  int   done_cnt   = 0;
  int   m_lives, m_hold;
  bit   m_go;
  bit   h0_busy_seen;

  // Reference model of one frame tick arriving at an idle/hold DUT.
  task automatic model_tick(output bit started);
    exp_t e;
    int gx, gy, px, py;
    logic [NG-1:0] fr;
    started = 0;
    if (m_go) return;
    if (m_hold > 0) begin
      m_hold--;
      return;
    end
    started = 1;
    fr = '0;
`ifdef COLLISION_FRIGHTENED_EN
    fr = ghost_frightened;
`endif
    px = int'(pacman_pos_x);
    py = int'(pacman_pos_y);
    e.mask = '0;
    e.eaten = '0;
    for (int i = 0; i < NG; i++) begin
      gx = int'(ghost_pos_x[i*11 +: 11]);
      gy = int'(ghost_pos_y[i*10 +: 10]);
      if ((gx / 16) == (px / 16) && (gy / 16) == (py / 16)) begin
        if (fr[i]) e.eaten[i] = 1'b1;
        else       e.mask[i]  = 1'b1;
      end
    end
    if (e.mask != 0) e.eaten = '0;
    e.id = 3'd0;
    for (int i = NG - 1; i >= 0; i--) if (e.mask[i]) e.id = 3'(i);
    e.dead = (e.mask != 0);
    if (e.dead) begin
      m_lives--;
      if (m_lives == 0) m_go = 1;
      else if (DH > 0) m_hold = DH;
    end
    e.lives = 3'(m_lives);
    e.go    = m_go;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      assertions++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: done=1 with no round pending, required none");
      end else begin
        mon_e = sb.pop_front();
        if (pacman_is_dead !== mon_e.dead) begin
          failures++;
          $display("FAIL sb_dead: got %b required %b", pacman_is_dead, mon_e.dead);
        end
        assertions++;
        if (hit_mask !== mon_e.mask) begin
          failures++;
          $display("FAIL sb_mask: got %b required %b", hit_mask, mon_e.mask);
        end
        assertions++;
        if (hit_ghost_id !== mon_e.id) begin
          failures++;
          $display("FAIL sb_id: got %0d required %0d", hit_ghost_id, mon_e.id);
        end
        assertions++;
        if (lives !== mon_e.lives) begin
          failures++;
          $display("FAIL sb_lives: got %0d required %0d", lives, mon_e.lives);
        end
        assertions++;
        if (game_over !== mon_e.go) begin
          failures++;
          $display("FAIL sb_game_over: got %b required %b", game_over, mon_e.go);
        end
`ifdef COLLISION_FRIGHTENED_EN
        assertions++;
        if (ghost_eaten !== mon_e.eaten) begin
          failures++;
          $display("FAIL sb_eaten: got %b required %b", ghost_eaten, mon_e.eaten);
        end
`endif
      end
    end
  end

  task automatic set_ghost(input int i, input int x, input int y);
    ghost_pos_x[i*11 +: 11] = 11'(x);
    ghost_pos_y[i*10 +: 10] = 10'(y);
  endtask

  task automatic set_all_far();
    for (int i = 0; i < NG; i++) set_ghost(i, 300, 300);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_tick = 1'b0;
    sb.delete();
    m_lives = 3;
    m_go = 0;
    m_hold = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One tick; checks done arrives on cycle 5 after the tick cycle, or not at all.
  task automatic do_tick(input string name);
    bit started;
    int first;
    bit any_busy;
    @(posedge clk);
    #1 frame_tick = 1'b1;
    model_tick(started);
    @(posedge clk);
    #1 frame_tick = 1'b0;
    first = 0;
    any_busy = 0;
    h0_busy_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (busy) any_busy = 1;
      if (h0_busy) h0_busy_seen = 1;
      if (done && first == 0) first = k;
    end
    assertions++;
    if (started && first != 5) begin
      failures++;
      $display("FAIL %s_done_latency: got cycle %0d required 5", name, first);
    end else if (!started && first != 0) begin
      failures++;
      $display("FAIL %s_no_done: got done at cycle %0d required none", name, first);
    end
    assertions++;
    if (any_busy != started) begin
      failures++;
      $display("FAIL %s_busy: got busy_seen=%b required %b", name, any_busy, started);
    end
  endtask

  task automatic check_reset_values(input string name);
    assertions++;
    if ({busy, done, pacman_is_dead, game_over, overrun} !== 5'b0) begin
      failures++;
      $display("FAIL %s_flags: got busy/done/dead/go/ovr=%b required 00000", name,
               {busy, done, pacman_is_dead, game_over, overrun});
    end
    assertions++;
    if (hit_ghost_id !== 3'd0 || hit_mask !== '0) begin
      failures++;
      $display("FAIL %s_hit: got id=%0d mask=%b required 0/0000", name, hit_ghost_id, hit_mask);
    end
    assertions++;
    if (lives !== 3'd3) begin
      failures++;
      $display("FAIL %s_lives: got %0d required 3", name, lives);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    check_reset_values("reset");
  endtask

  task automatic test_no_collision();
    do_reset();
    pacman_pos_x = 11'd100;
    pacman_pos_y = 10'd100;
    set_all_far();
    do_tick("no_collision");
  endtask

  task automatic test_tile_boundary();
    do_reset();
    pacman_pos_x = 11'd15;
    pacman_pos_y = 10'd15;
    set_all_far();
    set_ghost(0, 16, 15);
    set_ghost(1, 0, 0);
    set_ghost(3, 15, 16);
    do_tick("tile_boundary");
  endtask

  task automatic test_collision_and_hold();
    do_reset();
    pacman_pos_x = 11'd33;
    pacman_pos_y = 10'd40;
    set_all_far();
    set_ghost(2, 47, 35);
    set_ghost(3, 32, 47);
    do_tick("collision");
    set_all_far();
    do_tick("hold_1");
    do_tick("hold_2");
    do_tick("after_hold");
    assertions++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL hold_overrun: got %b required 0", overrun);
    end
  endtask

  task automatic test_overrun_and_midreset();
    bit started;
    int dc0;
    do_reset();
    pacman_pos_x = 11'd200;
    pacman_pos_y = 10'd200;
    set_all_far();
    set_ghost(1, 205, 210);
    @(posedge clk);
    #1 frame_tick = 1'b1;
    model_tick(started);
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    repeat (6) @(negedge clk);
    assertions++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %b required 1", overrun);
    end
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL overrun_round: got %0d rounds unreported required 0", sb.size());
    end
    repeat (4) @(posedge clk);
    // Second round interrupted by reset during its third cycle.
    #1 frame_tick = 1'b1;
    model_tick(started);
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    m_lives = 3;
    m_go = 0;
    m_hold = 0;
    #1 check_reset_values("midreset");
    dc0 = done_cnt;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    assertions++;
    if (done_cnt != dc0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_done: got %0d dones busy=%b required 0 dones busy=0",
               done_cnt - dc0, busy);
    end
  endtask

  task automatic test_game_over();
    int exp_h0_lives[8] = '{2, 1, 0, 0, 0, 0, 0, 0};
    bit exp_h0_go[8]    = '{0, 0, 1, 1, 1, 1, 1, 1};
    do_reset();
    pacman_pos_x = 11'd33;
    pacman_pos_y = 10'd40;
    set_all_far();
    set_ghost(0, 33, 40);
    for (int t = 0; t < 8; t++) begin
      do_tick($sformatf("game_over_t%0d", t));
      assertions++;
      if (h0_lives !== 3'(exp_h0_lives[t]) || h0_go !== exp_h0_go[t]) begin
        failures++;
        $display("FAIL h0_lives_t%0d: got lives=%0d go=%b required lives=%0d go=%b",
                 t, h0_lives, h0_go, exp_h0_lives[t], exp_h0_go[t]);
      end
      if (t >= 3) begin
        assertions++;
        if (h0_busy_seen !== 1'b0) begin
          failures++;
          $display("FAIL h0_ignored_t%0d: got busy_seen=1 required 0", t);
        end
      end
    end
    assertions++;
    if (game_over !== 1'b1 || lives !== 3'd0) begin
      failures++;
      $display("FAIL main_game_over: got go=%b lives=%0d required 1/0", game_over, lives);
    end
  endtask

`ifdef COLLISION_FRIGHTENED_EN
  task automatic test_frightened();
    do_reset();
    pacman_pos_x = 11'd33;
    pacman_pos_y = 10'd40;
    set_all_far();
    set_ghost(1, 40, 40);
    ghost_frightened = 4'b0010;
    do_tick("frightened_eat");
    set_ghost(0, 35, 36);
    do_tick("frightened_death");
    ghost_frightened = '0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    pacman_pos_x = '0;
    pacman_pos_y = '0;
    ghost_pos_x = '0;
    ghost_pos_y = '0;
`ifdef COLLISION_FRIGHTENED_EN
    ghost_frightened = '0;
`endif
    test_reset();
    test_no_collision();
    test_tile_boundary();
    test_collision_and_hold();
    test_overrun_and_midreset();
    test_game_over();
`ifdef COLLISION_FRIGHTENED_EN
    test_frightened();
`endif
    repeat (3) @(negedge clk);
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending rounds required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
